// File: rtl/uart_bus_master_if.sv
// UART byte-stream and J1 I/O bus signals of uart_bus_master.
// master: the bridge itself; slave: the uart core plus the addressed peripheral.
interface uart_bus_master_if;
    logic [7:0]  rx_data;
    logic        rx_avail;
    logic        rx_ack;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy;
    logic        cs;
    logic [15:0] addr;
    logic        rd;
    logic        wr;
    logic [15:0] bus_dout;
    logic [15:0] bus_din;
    logic        cmd_err;
    logic        active;

    modport master (
        input  rx_data, rx_avail, tx_busy, bus_din,
        output rx_ack, tx_data, tx_wr, cs, addr, rd, wr, bus_dout, cmd_err, active
    );

    modport slave (
        output rx_data, rx_avail, tx_busy, bus_din,
        input  rx_ack, tx_data, tx_wr, cs, addr, rd, wr, bus_dout, cmd_err, active
    );
endinterface

// File: rtl/uart_bus_master.sv
// UART command bridge onto the J1 I/O bus: 'W' AH AL DH DL writes, 'R' AH AL reads.
// Writes answer with ACK_BYTE; reads answer with the data word, high byte first.
module uart_bus_master #(
    parameter int unsigned RD_LAT         = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  ACK_BYTE       = 8'h4B
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    uart_bus_master_if.master bus
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned LAT_W = $clog2(RD_LAT + 1);
    localparam logic [7:0]  OP_WR = 8'h57;
    localparam logic [7:0]  OP_RD = 8'h52;

    typedef enum logic [3:0] {
        StIdle, StAHi, StALo, StDHi, StDLo, StBusWr, StBusRd, StRdWait, StSend, StTxGuard
    } state_e;

    state_e           r_state, w_next;
    logic             r_op_wr;
    logic             r_guard;
    logic [15:0]      r_addr;
    logic [15:0]      r_dout;
    logic [15:0]      r_txq;
    logic [1:0]       r_txcnt;
    logic [TMO_W-1:0] r_tmo;
    logic [LAT_W-1:0] r_lat;

    logic w_cmd_state, w_rx_state, w_accept, w_opc_ok, w_timeout, w_lat_done, w_tx_go;

    assign w_cmd_state = (r_state == StAHi) || (r_state == StALo) ||
                         (r_state == StDHi) || (r_state == StDLo);
    assign w_rx_state  = (r_state == StIdle) || w_cmd_state;
    // r_guard blocks the cycle after an ack, while the uart core is still dropping rx_avail
    assign w_accept    = w_rx_state && bus.rx_avail && !r_guard;
    assign w_opc_ok    = (bus.rx_data == OP_WR) || (bus.rx_data == OP_RD);
    assign w_timeout   = w_cmd_state && !w_accept && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
    assign w_lat_done  = (r_lat >= LAT_W'(RD_LAT));
    assign w_tx_go     = (r_state == StSend) && !bus.tx_busy;

    assign bus.addr     = r_addr;
    assign bus.bus_dout = r_dout;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= StIdle;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            StIdle:    if (w_accept && w_opc_ok) w_next = StAHi;
            StAHi:     if (w_accept) w_next = StALo;
                       else if (w_timeout) w_next = StIdle;
            StALo:     if (w_accept) w_next = r_op_wr ? StDHi : StBusRd;
                       else if (w_timeout) w_next = StIdle;
            StDHi:     if (w_accept) w_next = StDLo;
                       else if (w_timeout) w_next = StIdle;
            StDLo:     if (w_accept) w_next = StBusWr;
                       else if (w_timeout) w_next = StIdle;
            StBusWr:   w_next = StSend;
            StBusRd:   w_next = StRdWait;
            StRdWait:  if (w_lat_done) w_next = StSend;
            StSend:    if (w_tx_go) w_next = StTxGuard;
            StTxGuard: w_next = (r_txcnt != 2'd0) ? StSend : StIdle;
            default:   w_next = StIdle;
        endcase
    end

    always_comb begin
        bus.cs      = 1'b0;
        bus.rd      = 1'b0;
        bus.wr      = 1'b0;
        bus.rx_ack  = w_accept;
        bus.tx_wr   = w_tx_go;
        bus.tx_data = 8'h00;
        bus.cmd_err = w_timeout;
        bus.active  = (r_state != StIdle);
        case (r_state)
            StIdle:  bus.cmd_err = w_accept && !w_opc_ok;
            StBusWr: begin
                bus.cs = 1'b1;
                bus.wr = 1'b1;
            end
            StBusRd: begin
                bus.cs = 1'b1;
                bus.rd = 1'b1;
            end
            StSend:  bus.tx_data = w_tx_go ? r_txq[15:8] : 8'h00;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op_wr <= 1'b0;
            r_guard <= 1'b1;
            r_addr  <= '0;
            r_dout  <= '0;
            r_txq   <= '0;
            r_txcnt <= '0;
            r_tmo   <= '0;
            r_lat   <= '0;
        end else begin
            r_guard <= w_accept;
            if (w_accept)         r_tmo <= '0;
            else if (w_cmd_state) r_tmo <= r_tmo + TMO_W'(1);
            case (r_state)
                StIdle:  if (w_accept && w_opc_ok) r_op_wr <= (bus.rx_data == OP_WR);
                StAHi:   if (w_accept) r_addr[15:8] <= bus.rx_data;
                StALo:   if (w_accept) r_addr[7:0]  <= bus.rx_data;
                StDHi:   if (w_accept) r_dout[15:8] <= bus.rx_data;
                StDLo:   if (w_accept) r_dout[7:0]  <= bus.rx_data;
                StBusWr: begin
                    r_txq   <= {ACK_BYTE, 8'h00};
                    r_txcnt <= 2'd1;
                end
                StBusRd: begin
                    r_lat <= LAT_W'(1);
                    if (RD_LAT <= 1) r_txq <= bus.bus_din;
                end
                StRdWait: begin
                    if (!w_lat_done) begin
                        r_lat <= r_lat + LAT_W'(1);
                        if (r_lat + LAT_W'(1) == LAT_W'(RD_LAT)) r_txq <= bus.bus_din;
                    end else begin
                        r_txcnt <= 2'd2;
                    end
                end
                StSend: if (w_tx_go) begin
                    r_txq   <= {r_txq[7:0], 8'h00};
                    r_txcnt <= r_txcnt - 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: write, read with tx back-pressure, bad opcode,
// timeout, back-to-back rx_avail and reset mid-read.
module tb_uart_bus_master;

    logic clk = 1'b0;
    logic rst_n;
    logic [15:0] slave_rdata;

    uart_bus_master_if u_if ();

    uart_bus_master #(
        .RD_LAT         (1),
        .TIMEOUT_CYCLES (50),
        .ACK_BYTE       (8'h4B)
    ) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (u_if.master)
    );

    always #5 clk = ~clk;

    // Zero-wait peripheral: read data is valid only while the read strobe is up.
    assign u_if.bus_din = (u_if.cs && u_if.rd) ? slave_rdata : 16'h0000;

    int n_chk = 0;
    int n_err = 0;

    int cyc = 0, ack_cnt = 0, err_cnt = 0, wr_cnt = 0, rd_cnt = 0, tx_cnt = 0;
    int consec = 0, viol = 0, last_ack_cyc = 0, last_err_cyc = 0, last_tx_cyc = 0;
    logic        prev_ack = 1'b0;
    logic [15:0] wr_addr = '0, wr_dout = '0, rd_addr = '0;
    logic [7:0]  tx_log [0:31];

    always @(negedge clk) begin
        cyc++;
        if (u_if.rx_ack) begin
            if (prev_ack) consec++;
            ack_cnt++;
            last_ack_cyc = cyc;
        end
        prev_ack = u_if.rx_ack;
        if (u_if.cmd_err) begin
            err_cnt++;
            last_err_cyc = cyc;
        end
        if (u_if.cs && u_if.wr) begin
            wr_cnt++;
            wr_addr = u_if.addr;
            wr_dout = u_if.bus_dout;
        end
        if (u_if.cs && u_if.rd) begin
            rd_cnt++;
            rd_addr = u_if.addr;
        end
        if ((u_if.rd && u_if.wr) || (u_if.cs != (u_if.rd || u_if.wr))) viol++;
        if (u_if.tx_wr) begin
            if (u_if.tx_busy) viol++;
            if (tx_cnt < 32) tx_log[tx_cnt] = u_if.tx_data;
            tx_cnt++;
            last_tx_cyc = cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one byte like the uart core does; drop rx_avail on the acking edge.
    task automatic rx_byte(input logic [7:0] b);
        int k = 0;
        bit got = 1'b0;
        u_if.rx_data  = b;
        u_if.rx_avail = 1'b1;
        while (!got && k < 200) begin
            @(negedge clk);
            if (u_if.rx_ack) got = 1'b1;
            @(posedge clk);
            #1;
            k++;
        end
        u_if.rx_avail = 1'b0;
        check_eq("rx_accept", 32'(got), 32'd1);
    endtask

    task automatic wait_tx(input int target, input string tag);
        int k = 0;
        while (tx_cnt < target && k < 100) begin
            step(1);
            k++;
        end
        check_eq(tag, tx_cnt, target);
    endtask

    int a0, w0, r0, t0, e0, fall_cyc;

    initial begin
        rst_n         = 1'b0;
        u_if.rx_avail = 1'b1;
        u_if.rx_data  = 8'h57;
        u_if.tx_busy  = 1'b0;
        slave_rdata   = 16'h0000;
        step(3);
        check_eq("rst_rx_ack", 32'(u_if.rx_ack), 32'd0);
        check_eq("rst_active", 32'(u_if.active), 32'd0);
        check_eq("rst_cs", 32'(u_if.cs), 32'd0);
        check_eq("rst_tx_wr", 32'(u_if.tx_wr), 32'd0);
        check_eq("rst_cmd_err", 32'(u_if.cmd_err), 32'd0);
        check_eq("rst_addr", 32'(u_if.addr), 32'd0);
        u_if.rx_avail = 1'b0;
        rst_n         = 1'b1;
        step(2);

        // Write 0x1234 to 0x0002
        a0 = ack_cnt; w0 = wr_cnt; t0 = tx_cnt;
        rx_byte(8'h57); rx_byte(8'h00); rx_byte(8'h02); rx_byte(8'h12); rx_byte(8'h34);
        wait_tx(t0 + 1, "wr_tx_count");
        step(2);
        check_eq("wr_strobes", wr_cnt - w0, 1);
        check_eq("wr_addr", 32'(wr_addr), 32'h0002);
        check_eq("wr_dout", 32'(wr_dout), 32'h1234);
        check_eq("wr_ack_byte", 32'(tx_log[t0]), 32'h4B);
        check_eq("wr_rx_acks", ack_cnt - a0, 5);
        check_eq("wr_idle", 32'(u_if.active), 32'd0);
        check_eq("addr_hold", 32'(u_if.addr), 32'h0002);
        check_eq("dout_hold", 32'(u_if.bus_dout), 32'h1234);

        // Read 0x0006 with tx_busy holding off the second byte
        slave_rdata = 16'hABCD;
        r0 = rd_cnt; t0 = tx_cnt;
        rx_byte(8'h52); rx_byte(8'h00); rx_byte(8'h06);
        wait_tx(t0 + 1, "rd_tx_first");
        u_if.tx_busy = 1'b1;
        step(20);
        check_eq("rd_hold_busy", tx_cnt, t0 + 1);
        fall_cyc = cyc;
        u_if.tx_busy = 1'b0;
        wait_tx(t0 + 2, "rd_tx_second");
        step(2);
        check_eq("rd_after_busy", 32'(last_tx_cyc > fall_cyc), 32'd1);
        check_eq("rd_strobes", rd_cnt - r0, 1);
        check_eq("rd_addr", 32'(rd_addr), 32'h0006);
        check_eq("rd_byte_hi", 32'(tx_log[t0]), 32'hAB);
        check_eq("rd_byte_lo", 32'(tx_log[t0 + 1]), 32'hCD);
        check_eq("rd_idle", 32'(u_if.active), 32'd0);

        // Bad opcode, then a normal read
        e0 = err_cnt;
        rx_byte(8'h41);
        check_eq("bad_err", err_cnt - e0, 1);
        check_eq("bad_err_cycle", last_err_cyc, last_ack_cyc);
        check_eq("bad_idle", 32'(u_if.active), 32'd0);
        slave_rdata = 16'h1357;
        t0 = tx_cnt;
        rx_byte(8'h52); rx_byte(8'h00); rx_byte(8'h02);
        wait_tx(t0 + 2, "bad_rd_tx");
        check_eq("bad_rd_addr", 32'(rd_addr), 32'h0002);
        check_eq("bad_rd_hi", 32'(tx_log[t0]), 32'h13);
        check_eq("bad_rd_lo", 32'(tx_log[t0 + 1]), 32'h57);
        step(3);

        // Timeout after two bytes of a write
        e0 = err_cnt; w0 = wr_cnt;
        rx_byte(8'h57); rx_byte(8'h00);
        for (int k = 0; k < 100 && err_cnt == e0; k++) step(1);
        step(2);
        check_eq("tmo_err", err_cnt - e0, 1);
        check_eq("tmo_latency", last_err_cyc - last_ack_cyc, 50);
        check_eq("tmo_no_wr", wr_cnt - w0, 0);
        check_eq("tmo_idle", 32'(u_if.active), 32'd0);
        w0 = wr_cnt; t0 = tx_cnt;
        rx_byte(8'h57); rx_byte(8'h00); rx_byte(8'h10); rx_byte(8'hBE); rx_byte(8'hEF);
        wait_tx(t0 + 1, "tmo_wr_tx");
        check_eq("tmo_wr_strobe", wr_cnt - w0, 1);
        check_eq("tmo_wr_addr", 32'(wr_addr), 32'h0010);
        check_eq("tmo_wr_dout", 32'(wr_dout), 32'hBEEF);
        step(3);

        // rx_avail stuck high with 0x57 for 30 cycles
        a0 = ack_cnt; w0 = wr_cnt;
        u_if.rx_data  = 8'h57;
        u_if.rx_avail = 1'b1;
        step(30);
        u_if.rx_avail = 1'b0;
        check_eq("stuck_no_consec", consec, 0);
        check_eq("stuck_acks", ack_cnt - a0, 13);
        check_eq("stuck_writes", wr_cnt - w0, 2);
        check_eq("stuck_wr_dout", 32'(wr_dout), 32'h5757);
        step(100);
        check_eq("stuck_idle", 32'(u_if.active), 32'd0);

        // Reset while waiting on read data
        slave_rdata = 16'h2222;
        rx_byte(8'h52); rx_byte(8'h00); rx_byte(8'h06);
        check_eq("rst_in_bus_rd", 32'(u_if.rd), 32'd1);
        step(1);
        check_eq("rst_in_rd_wait", 32'(u_if.active), 32'd1);
        t0 = tx_cnt;
        rst_n = 1'b0;
        #1;
        check_eq("arst_cs", 32'(u_if.cs), 32'd0);
        check_eq("arst_rd", 32'(u_if.rd), 32'd0);
        check_eq("arst_tx_wr", 32'(u_if.tx_wr), 32'd0);
        check_eq("arst_active", 32'(u_if.active), 32'd0);
        step(3);
        rst_n = 1'b1;
        step(20);
        check_eq("arst_no_tx", tx_cnt - t0, 0);
        w0 = wr_cnt;
        rx_byte(8'h57); rx_byte(8'h00); rx_byte(8'h20); rx_byte(8'hCA); rx_byte(8'hFE);
        wait_tx(t0 + 1, "arst_wr_tx");
        check_eq("arst_wr_strobe", wr_cnt - w0, 1);
        check_eq("arst_wr_dout", 32'(wr_dout), 32'hCAFE);
        check_eq("arst_ack_byte", 32'(tx_log[t0]), 32'h4B);
        step(3);

        check_eq("bus_protocol", viol, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- UART-driven initiator on the J1 I/O bus: the other end of the cs/addr/rd/wr register interface that UART peripherals respond on.
- Parses a byte-stream command protocol from the UART receiver and issues single 16-bit bus writes and reads.
- Returns read data and write acknowledgements through the UART transmitter.
- Used for board bring-up and debug access to peripherals without running J1 firmware; sits between the uart core and the I/O bus mux.

Parameters:
- RD_LAT, 1: clock cycles from the rising edge that asserts rd to the rising edge that samples bus_din.
- TIMEOUT_CYCLES, 1000000: maximum idle cycles between bytes of one command before it is abandoned.
- ACK_BYTE, 8'h4B: byte transmitted after each completed write.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- rx_data  input  8  received byte from the uart core.
- rx_avail  input  1  received byte valid.
- rx_ack  output  1  one-cycle pulse; consumes rx_data.
- tx_data  output  8  byte to transmit.
- tx_wr  output  1  one-cycle transmit strobe.
- tx_busy  input  1  transmitter busy.
- cs  output  1  bus chip select.
- addr  output  16  bus address.
- rd  output  1  bus read strobe.
- wr  output  1  bus write strobe.
- bus_dout  output  16  write data.
- bus_din  input  16  read data.
- cmd_err  output  1  one-cycle pulse on bad opcode or timeout.
- active  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE. All outputs 0. Internal addr/data/timeout registers cleared. Any in-flight command is discarded; the bus strobe drops immediately.
- Protocol, write: 8'h57 ('W'), ADDR_HI, ADDR_LO, DATA_HI, DATA_LO. Response: ACK_BYTE.
- Protocol, read: 8'h52 ('R'), ADDR_HI, ADDR_LO. Response: DATA_HI, then DATA_LO.
- Byte accept: in any receive state, when rx_avail=1 and no guard is active, capture rx_data and pulse rx_ack for one cycle. The next cycle is a guard cycle in which rx_avail is ignored, so no byte is double-consumed.
- States and transitions:
  - IDLE: on accepting 8'h57 go to A_HI with op=write; on 8'h52 go to A_HI with op=read. Any other byte is consumed, cmd_err pulses, and the FSM stays in IDLE.
  - A_HI then A_LO: load addr[15:8], then addr[7:0]. After A_LO, a write goes to D_HI and a read goes to BUS_RD.
  - D_HI then D_LO: load bus_dout[15:8], then [7:0]. After D_LO go to BUS_WR.
  - BUS_WR: cs=1 and wr=1 for exactly one cycle, with addr and bus_dout stable. Next state is SEND with a one-byte queue of ACK_BYTE.
  - BUS_RD: cs=1 and rd=1 for exactly one cycle, then RD_WAIT. Capture bus_din on the RD_LAT-th rising edge after the strobe edge. Queue the two data bytes, high first, and go to SEND.
  - SEND: when tx_busy=0, drive tx_data and pulse tx_wr for one cycle, then go to TX_GUARD.
  - TX_GUARD: a fixed one-cycle wait so tx_busy can rise. Then return to SEND if bytes remain, else IDLE.
- addr and bus_dout hold their last values outside strobes. cs/rd/wr are never asserted together, and never outside BUS_WR/BUS_RD.
- Timeout:
  - Counter clears on every accepted byte and increments each cycle in A_HI, A_LO, D_HI and D_LO.
  - When it reaches TIMEOUT_CYCLES-1: pulse cmd_err, go to IDLE, and issue no bus cycle.
  - IDLE, bus and send states never time out.
- rx bytes arriving during BUS_*, RD_WAIT, SEND or TX_GUARD are not acked. They stay pending in the uart core and are processed once back in IDLE.
- tx_busy=1 on entry to SEND: tx_wr is held off indefinitely, with no byte loss and no timeout.

Test Plan:
- Write: rx bytes 57,00,02,12,34 → one cycle with cs=1, wr=1, addr=16'h0002, bus_dout=16'h1234; then tx_wr with tx_data=8'h4B; 5 rx_ack pulses total; active returns to 0.
- Read, RD_LAT=1: rx bytes 52,00,06, bus_din=16'hABCD → one cycle with cs=1, rd=1, addr=16'h0006; tx bytes AB then CD; with tx_busy held high 20 cycles after the first byte, the second tx_wr occurs only after tx_busy falls.
- Bad opcode: rx byte 41 → rx_ack pulse, cmd_err pulse, FSM stays IDLE; a following 52,00,02 read completes normally.
- Timeout (TIMEOUT_CYCLES=50): rx bytes 57,00 then silence → cmd_err exactly 50 cycles after the second ack; no wr strobe; a later full write command succeeds.
- rx_avail held high continuously with rx_data=57 → acks spaced at least 2 cycles apart, never on consecutive cycles.
- Reset: assert rst=0 during RD_WAIT → cs/rd/tx_wr/active go low asynchronously; after release no tx byte is sent, and a new command works.
